// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the counter-width helper.
package seq_shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/done handshake and operand/product bus of the sequential multiplier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/seq_shift_add_mult_twos_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x (mod 2^WIDTH).
module seq_shift_add_mult_twos_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = x;
    if (neg) y = ~x + 1'b1;
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-and-add multiplier: one adder iterated WIDTH times on
// operand magnitudes, sign applied to the product on entry to DONE.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_shift_add_mult_if.slave bus
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   p_next;
  logic                 accept;

  // Operand magnitudes; raw operands pass through in unsigned mode.
  seq_shift_add_mult_twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .x   (bus.a),
    .neg (bus.signed_mode & bus.a[WIDTH-1]),
    .y   (abs_a)
  );

  seq_shift_add_mult_twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .x   (bus.b),
    .neg (bus.signed_mode & bus.b[WIDTH-1]),
    .y   (abs_b)
  );

  always_comb begin
    acc_next = acc;
    if (mag_b[0]) acc_next = acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
  end

  // Sign fix on the final partial sum, captured into p on the last iteration.
  seq_shift_add_mult_twos_abs #(.WIDTH(2*WIDTH)) u_fix_p (
    .x   (acc_next),
    .neg (neg),
    .y   (p_next)
  );

  assign accept = bus.start && (state != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept) begin
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= ST_RUN;
          end else begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            p_r    <= p_next;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Randomised self-checking bench for seq_shift_add_mult (WIDTH=8) against
// a plain integer-multiply reference.
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_shift_add_mult_if #(.WIDTH(W)) bus ();

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic sm);
    longint r;
    if (sm) r = longint'($signed(x)) * longint'($signed(y));
    else    r = longint'(x) * longint'(y);
    return r[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse; returns product, ticks until done and busy-high count.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic sm, output logic [2*W-1:0] got,
                        output int lat, output int busy_cnt, output bit ok);
    bus.a = ta; bus.b = tb_v; bus.signed_mode = sm; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = 'x; bus.b = 'x; bus.signed_mode = 1'bx;
    lat = 0; busy_cnt = 0;
    while (!bus.done && lat < 4*W) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    ok  = bus.done;
    got = bus.p;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ta,
                          input logic [W-1:0] tb_v, input logic sm);
    logic [2*W-1:0] got, exp;
    int lat, bc;
    bit ok;
    exp = ref_mult(ta, tb_v, sm);
    run_op(ta, tb_v, sm, got, lat, bc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s timeout: no done within %0d cycles", name, 4*W);
    end else if (got !== exp) begin
      miscompares++;
      $display("FAIL %s a=%0d b=%0d sm=%0d: p=%h expected %h", name, ta, tb_v, sm, got, exp);
    end
    vectors++;
    if (lat != W || bc != W) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d, busy %0d cycles, expected %0d", name, lat, bc, W);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.p !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b p=%h expected 0 0 0", bus.busy, bus.done, bus.p);
    end
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_unsigned_max();
    int dones;
    check_op("unsigned_max", 8'hFF, 8'hFF, 1'b0);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_in_done: busy=%b expected 0", bus.busy);
    end
    dones = 0;
    repeat (3) begin
      tick();
      if (bus.done) dones++;
    end
    vectors++;
    if (bus.p !== 16'hFE01 || dones != 0) begin
      miscompares++;
      $display("FAIL p_hold: p=%h dones=%0d expected fe01 0", bus.p, dones);
    end
  endtask

  task automatic test_signed_edges();
    check_op("neg_min_sq", 8'h80, 8'h80, 1'b1);
    check_op("neg_min_x_max", 8'h80, 8'h7F, 1'b1);
    check_op("three_x_m1", 8'h03, 8'hFF, 1'b1);
    check_op("zero_x_neg", 8'h00, 8'hFB, 1'b1);
    check_op("unsigned_hi", 8'h80, 8'hFF, 1'b0);
  endtask

  task automatic test_ignored_start();
    logic [2*W-1:0] exp, seen;
    int dones;
    exp = ref_mult(8'd37, 8'd201, 1'b0);
    bus.a = 8'd37; bus.b = 8'd201; bus.signed_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.a = 8'd99; bus.b = 8'd77; bus.signed_mode = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dones = 0; seen = '0;
    repeat (3*W) begin
      if (bus.done) begin dones++; seen = bus.p; end
      tick();
    end
    vectors++;
    if (dones != 1 || seen !== exp) begin
      miscompares++;
      $display("FAIL ignored_start: dones=%0d p=%h expected 1 %h", dones, seen, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] na [5];
    logic [W-1:0] nb [5];
    logic         ns [5];
    int k, gap, guard;
    for (int i = 0; i < 5; i++) begin
      na[i] = W'($urandom); nb[i] = W'($urandom); ns[i] = 1'($urandom);
    end
    bus.a = na[0]; bus.b = nb[0]; bus.signed_mode = ns[0]; bus.start = 1'b1;
    tick();
    k = 0; gap = 0; guard = 0;
    while (k < 5 && guard < 100) begin
      vectors++;
      if (bus.busy === bus.done) begin
        miscompares++;
        $display("FAIL b2b_busy: busy=%b done=%b expected complementary", bus.busy, bus.done);
      end
      if (bus.done) begin
        vectors++;
        if (bus.p !== ref_mult(na[k], nb[k], ns[k])) begin
          miscompares++;
          $display("FAIL b2b_p%0d: p=%h expected %h", k, bus.p, ref_mult(na[k], nb[k], ns[k]));
        end
        if (k > 0) begin
          vectors++;
          if (gap != W + 1) begin
            miscompares++;
            $display("FAIL b2b_gap%0d: %0d cycles expected %0d", k, gap, W + 1);
          end
        end
        k++;
        if (k < 5) begin
          bus.a = na[k]; bus.b = nb[k]; bus.signed_mode = ns[k];
        end
        gap = 0;
      end
      tick();
      gap++; guard++;
    end
    bus.start = 1'b0;
    vectors++;
    if (k < 5) begin
      miscompares++;
      $display("FAIL b2b_timeout: %0d results, expected 5", k);
    end
    repeat (W + 2) tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.a = 8'd200; bus.b = 8'd100; bus.signed_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.p !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: p=%h busy=%b done=%b expected 0 0 0", bus.p, bus.busy, bus.done);
    end
    #3 rst_n = 1'b1;
    dones = 0;
    repeat (W + 2) begin
      tick();
      if (bus.done) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL reset_mid_done: %0d done pulses expected 0", dones);
    end
    check_op("after_reset", 8'd0, 8'd255, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      check_op("random", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_unsigned_max();
    test_signed_edges();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised, multi-cycle shift-and-add integer multiplier with a start/done handshake and selectable signed/unsigned mode.
- Uses one adder iterated WIDTH times, not a combinational adder tree, so area stays small as WIDTH grows.
- Sits in the arithmetic library as the sequential successor to the combinational 4x4 array multiplier. It is used where the operand width makes a full array too large.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; operands are sampled in the same cycle.
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse: p is valid.
- p  output  2*WIDTH  product; held until the next accepted start.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, busy=0, done=0, p=0, all internal registers=0.
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept rule: start is accepted when state is IDLE or DONE (back-to-back operations allowed). start while in RUN is ignored; operands are not re-sampled.
- On accept, register:
  - mag_a = |a| and mag_b = |b| when signed_mode=1; raw a and b otherwise (unsigned, WIDTH bits each).
  - neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]).
  - acc = 0, cnt = 0. Go to RUN.
- RUN, one iteration per cycle:
  - If mag_b[0]: acc = acc + (mag_a << cnt). acc is 2*WIDTH bits; the add is zero-extended, with no truncation.
  - mag_b >>= 1; cnt++.
  - When cnt == WIDTH-1 on the current iteration, go to DONE after the update.
  - RUN lasts exactly WIDTH cycles; there is no early termination, so latency is data-independent.
- Entering DONE: p <= neg ? (~acc + 1) : acc, taken mod 2^(2*WIDTH), registered on the same edge. done=1.
- DONE leaves to RUN if start is accepted, else to IDLE.
- Latency: start sampled at edge N; done is high in the cycle after edge N+WIDTH. That is WIDTH+1 cycles start-to-done. Throughput is one result per WIDTH+1 cycles.
- p changes only on entry to DONE. It holds through IDLE and RUN of the next operation.
- Boundary conditions:
  - Most-negative operand (-2^(WIDTH-1)): its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits. The signed product range is [-2^(2W-2)+2^(W-1), 2^(2W-2)], which always fits 2*WIDTH bits.
  - Zero operand: p=0 and neg is irrelevant, since ~0+1 = 0.
  - Unsigned max: (2^W-1)^2 fits 2*WIDTH bits.
- Reset mid-operation: returns to IDLE immediately. p=0, done is not pulsed, and the operation is lost.
- X on a, b or signed_mode while start=0 must not propagate into state.

Decomposition:
- Shared package/header mult_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - function clog2 for the cnt width, $clog2(WIDTH).
- One natural sub-module: twos_abs (WIDTH-bit conditional negate, combinational). It is instantiated for a, b, and at 2*WIDTH for the final product sign fix.
- Everything else is inline.

Test Plan:
- WIDTH=4, unsigned, a=15, b=15, start one cycle -> busy high 4 cycles; done pulses 5 cycles after start; p=8'hE1 (225); p holds afterwards.
- WIDTH=4, signed, a=4'b1000 (-8), b=4'b1000 (-8) -> p=8'h40 (64). Then a=-8, b=7 -> p=8'hC8 (-56). Then a=3, b=-1 -> p=8'hFD.
- WIDTH=8, start asserted again 2 cycles into RUN with different operands -> ignored; p = product of the first operands; done pulses exactly once.
- WIDTH=8, start held high continuously, with operands changed in each DONE cycle -> a result every 9 cycles. Each p matches its own operand pair; busy is low only during the DONE cycles.
- WIDTH=8, rst_n pulled low at cycle 3 of RUN (a=200, b=100, unsigned) -> p=0, busy=0, no done pulse. The next start with a=0, b=255 gives p=0 after 9 cycles.
- Randomised sweep (WIDTH=4 exhaustive over all 256x2 modes; WIDTH=16 with 10k random pairs) against a reference $signed/$unsigned multiply -> zero mismatches.
